// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and forwarding helper for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } memwait_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // MEM result is younger than WB result, so it takes priority.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            return FWD_MEM;
        end
        if (wr_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
// master: datapath side (drives register ids / status, receives stall/flush/forward)
// slave : hazard controller side
interface hazard_ctrl_if;

    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       ResultSrcE_zero;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       PCSrcE;
    logic       MemReqM;
    logic       MemReadyM;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       MemTimeout;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemTimeout
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemTimeout
    );

endinterface

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// rtl/hazard_ctrl_mem_wait_fsm.sv - data-memory wait tracker with timeout
// Ports: clk, reset (sync, active-high), MemReqM, MemReadyM in;
//        memStall (freeze pipeline), MemTimeout (state is ERROR) out.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic MemReqM,
    input  logic MemReadyM,
    output logic memStall,
    output logic MemTimeout
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    if (MAX_WAIT < 2) begin : g_bad_max_wait
        $error("mem_wait_fsm: MAX_WAIT must be >= 2");
    end

    memwait_state_e          state, state_next;
    logic [WCNT_W-1:0]       wcnt, wcnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // wcnt counts not-ready cycles already stalled, including the IDLE cycle
    // that started the wait.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        memStall   = 1'b0;
        MemTimeout = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    memStall   = 1'b1;
                    state_next = WAIT;
                    wcnt_next  = WCNT_ONE;
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_next = IDLE;
                    wcnt_next  = '0;
                end else begin
                    memStall = 1'b1;
                    if (wcnt == WCNT_LAST) begin
                        state_next = ERROR;
                    end else begin
                        wcnt_next = wcnt + WCNT_ONE;
                    end
                end
            end
            ERROR: begin
                memStall   = 1'b1;
                MemTimeout = 1'b1;
            end
            default: begin
                state_next = IDLE;
                wcnt_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard controller: forwarding, load-use, branch flush, memory freeze
// Ports: clk, reset (sync, active-high), hz (hazard_ctrl_if.slave: register ids, status in;
//        Stall*/Flush*/Forward*/MemTimeout out).
// Optional macro HAZARD_PERF_EN adds saturating counters LwStallCnt, MemStallCnt, FlushCnt (CNT_W bits).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
)
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] LwStallCnt,
    output logic [CNT_W-1:0] MemStallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    logic     lw_stall;
    logic     mem_stall_raw;
    logic     mem_timeout_raw;
    logic     mem_stall;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    mem_wait_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (hz.MemReqM),
        .MemReadyM  (hz.MemReadyM),
        .memStall   (mem_stall_raw),
        .MemTimeout (mem_timeout_raw)
    );

    // The FSM only clears on the reset edge; mask its outputs during the
    // reset cycle so the pipeline sees clean controls immediately.
    assign mem_stall = mem_stall_raw & ~reset;

    assign lw_stall = hz.ResultSrcE_zero && (hz.RdE != REG_X0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            fwd_a = fwd_select(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            fwd_b = fwd_select(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        end
    end

    // A branch resolved while memory stalls is held in EX, so its flush is
    // suppressed until the freeze lifts.
    always_comb begin
        hz.StallF     = 1'b0;
        hz.StallD     = 1'b0;
        hz.StallE     = 1'b0;
        hz.StallM     = 1'b0;
        hz.FlushW     = 1'b0;
        hz.FlushD     = 1'b1;
        hz.FlushE     = 1'b1;
        hz.MemTimeout = 1'b0;
        if (!reset) begin
            hz.StallF     = mem_stall | lw_stall;
            hz.StallD     = mem_stall | lw_stall;
            hz.StallE     = mem_stall;
            hz.StallM     = mem_stall;
            hz.FlushW     = mem_stall;
            hz.FlushD     = hz.PCSrcE & ~mem_stall;
            hz.FlushE     = (lw_stall | hz.PCSrcE) & ~mem_stall;
            hz.MemTimeout = mem_timeout_raw;
        end
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            LwStallCnt  <= '0;
            MemStallCnt <= '0;
            FlushCnt    <= '0;
        end else begin
            if (lw_stall && (LwStallCnt != CNT_MAX)) begin
                LwStallCnt <= LwStallCnt + CNT_ONE;
            end
            if (mem_stall && (MemStallCnt != CNT_MAX)) begin
                MemStallCnt <= MemStallCnt + CNT_ONE;
            end
            if (hz.FlushD && (FlushCnt != CNT_MAX)) begin
                FlushCnt <= FlushCnt + CNT_ONE;
            end
        end
    end
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be >= 1");
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (table vectors + multi-cycle sequences)
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] lw_cnt;
    logic [31:0] mem_cnt;
    logic [31:0] fl_cnt;
`endif

    hazard_ctrl #(
        .MAX_WAIT (4),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
`ifdef HAZARD_PERF_EN
        ,
        .LwStallCnt  (lw_cnt),
        .MemStallCnt (mem_cnt),
        .FlushCnt    (fl_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       ld, rwm, rww, pcsrc;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[11];

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemTimeout}
    function automatic logic [11:0] pk(input logic sfd, input logic mem, input logic fd,
                                       input logic fe, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic to);
        return {sfd, sfd, mem, mem, fd, fe, mem, fa, fb, to};
    endfunction

    function automatic logic [11:0] outs();
        return {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
                hif.FlushW, hif.ForwardAE, hif.ForwardBE, hif.MemTimeout};
    endfunction

    function automatic vec_t mk(input string name,
                                input logic [4:0] rs1d, input logic [4:0] rs2d,
                                input logic [4:0] rs1e, input logic [4:0] rs2e,
                                input logic [4:0] rde, input logic [4:0] rdm,
                                input logic [4:0] rdw, input logic ld, input logic rwm,
                                input logic rww, input logic pcsrc, input logic [11:0] exp);
        vec_t v;
        v.name = name; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.ld = ld; v.rwm = rwm; v.rww = rww;
        v.pcsrc = pcsrc; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.ResultSrcE_zero = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    task automatic apply(input vec_t v);
        hif.Rs1D = v.rs1d; hif.Rs2D = v.rs2d; hif.Rs1E = v.rs1e; hif.Rs2E = v.rs2e;
        hif.RdE = v.rde; hif.RdM = v.rdm; hif.RdW = v.rdw;
        hif.ResultSrcE_zero = v.ld; hif.RegWriteM = v.rwm; hif.RegWriteW = v.rww;
        hif.PCSrcE = v.pcsrc;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        //                  name        rs1d rs2d rs1e rs2e rde rdm rdw ld rwm rww br  expected
        vecs[0]  = mk("fwd_mem",    0,  0,  5,  0,  0,  5,  5, 0, 1, 1, 0, pk(0,0,0,0,2'b10,2'b00,0));
        vecs[1]  = mk("fwd_wb",     0,  0,  5,  0,  0,  5,  5, 0, 0, 1, 0, pk(0,0,0,0,2'b01,2'b00,0));
        vecs[2]  = mk("fwd_x0",     0,  0,  5,  0,  0,  0,  0, 0, 1, 1, 0, pk(0,0,0,0,2'b00,2'b00,0));
        vecs[3]  = mk("fwd_split",  0,  0,  3,  9,  0,  3,  9, 0, 1, 1, 0, pk(0,0,0,0,2'b10,2'b01,0));
        vecs[4]  = mk("fwd_both",   0,  0,  6,  6,  0,  6,  2, 0, 1, 1, 0, pk(0,0,0,0,2'b10,2'b10,0));
        vecs[5]  = mk("lu_rs2",     0,  7,  0,  0,  7,  0,  0, 1, 0, 0, 0, pk(1,0,0,1,2'b00,2'b00,0));
        vecs[6]  = mk("lu_rd0",     0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, pk(0,0,0,0,2'b00,2'b00,0));
        vecs[7]  = mk("lu_rs1",     7,  0,  0,  0,  7,  0,  0, 1, 0, 0, 0, pk(1,0,0,1,2'b00,2'b00,0));
        vecs[8]  = mk("no_load",    7,  0,  0,  0,  7,  0,  0, 0, 0, 0, 0, pk(0,0,0,0,2'b00,2'b00,0));
        vecs[9]  = mk("branch",     0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, pk(0,0,1,1,2'b00,2'b00,0));
        vecs[10] = mk("lu_branch",  4,  0,  0,  0,  4,  0,  0, 1, 0, 0, 1, pk(1,0,1,1,2'b00,2'b00,0));

        // Reset: forwarding/load-use inputs active must still give clean controls.
        clear_in();
        reset = 1'b1;
        hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1;
        hif.ResultSrcE_zero = 1; hif.RdE = 7; hif.Rs2D = 7;
        cyc(); cyc(); #1;
        check("reset_outs", 32'(outs()), 32'(pk(0,0,1,1,2'b00,2'b00,0)));
        clear_in();
        cyc(); reset = 1'b0; #1;
        check("idle_after_reset", 32'(outs()), 32'(pk(0,0,0,0,2'b00,2'b00,0)));

        foreach (vecs[i]) begin
            cyc();
            apply(vecs[i]);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end
        cyc(); clear_in();

        // Memory wait: 3 not-ready cycles then ready.
        hif.MemReqM = 1; hif.MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait3_c%0d", i), 32'(outs()), 32'(pk(1,1,0,0,2'b00,2'b00,0)));
            cyc();
        end
        hif.MemReadyM = 1; #1;
        check("wait3_release", 32'(outs()), 32'(pk(0,0,0,0,2'b00,2'b00,0)));
        cyc(); hif.MemReqM = 1; hif.MemReadyM = 1; #1;
        check("wait3_idle_ready", 32'(outs()), 32'(pk(0,0,0,0,2'b00,2'b00,0)));
        cyc(); clear_in();

        // Branch during 2-cycle wait: flush deferred to the release cycle.
        hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("br_wait_c%0d", i), 32'(outs()), 32'(pk(1,1,0,0,2'b00,2'b00,0)));
            cyc();
        end
        hif.MemReadyM = 1; #1;
        check("br_wait_release", 32'(outs()), 32'(pk(0,0,1,1,2'b00,2'b00,0)));
        cyc(); clear_in();

        // Timeout with MAX_WAIT=4: 4 stalled cycles, then sticky ERROR.
        hif.MemReqM = 1; hif.MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to_wait_c%0d", i), 32'(outs()), 32'(pk(1,1,0,0,2'b00,2'b00,0)));
            cyc();
        end
        #1;
        check("to_error", 32'(outs()), 32'(pk(1,1,0,0,2'b00,2'b00,1)));
        cyc(); hif.MemReadyM = 1; hif.MemReqM = 0; hif.PCSrcE = 1; #1;
        check("to_error_sticky", 32'(outs()), 32'(pk(1,1,0,0,2'b00,2'b00,1)));
        cyc(); clear_in(); reset = 1'b1; #1;
        check("to_reset_during", 32'(outs()), 32'(pk(0,0,1,1,2'b00,2'b00,0)));
        cyc(); reset = 1'b0; #1;
        check("to_reset_cleared", 32'(outs()), 32'(pk(0,0,0,0,2'b00,2'b00,0)));

`ifdef HAZARD_PERF_EN
        check("perf_lw_reset", lw_cnt, 32'd0);
        check("perf_mem_reset", mem_cnt, 32'd0);
        check("perf_fl_reset", fl_cnt, 32'd0);
        cyc(); hif.ResultSrcE_zero = 1; hif.RdE = 7; hif.Rs1D = 7;
        cyc(); clear_in(); hif.MemReqM = 1; hif.MemReadyM = 0;
        cyc(); cyc(); cyc(); hif.MemReadyM = 1;
        cyc(); clear_in(); hif.PCSrcE = 1;
        cyc(); clear_in(); #1;
        check("perf_lw", lw_cnt, 32'd1);
        check("perf_mem", mem_cnt, 32'd3);
        check("perf_flush", fl_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
